// File: rtl/iir_pkg.sv
// Shared definitions for the IIR coefficient loader and filter: word order, set size and loader
// states.
package iir_pkg;

  localparam int unsigned COEF_W_DEFAULT = 32;

  localparam int unsigned B0_IDX   = 0;
  localparam int unsigned B1_IDX   = 1;
  localparam int unsigned B2_IDX   = 2;
  localparam int unsigned A1_IDX   = 3;
  localparam int unsigned A2_IDX   = 4;
  localparam int unsigned NUM_COEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    PENDING
  } loader_state_e;

endpackage

// File: rtl/iir_coef_loader.sv
// Collects a framed coefficient set into a shadow bank and swaps it into the live registers on a
// sample-boundary strobe. Define IIR_COEF_CHECKSUM_EN to require a trailing checksum word.
module iir_coef_loader
  import iir_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [COEF_W-1:0] s_data,
  input  logic              s_last,
  input  logic              commit_strobe,
  output logic [COEF_W-1:0] b0,
  output logic [COEF_W-1:0] b1,
  output logic [COEF_W-1:0] b2,
  output logic [COEF_W-1:0] a1,
  output logic [COEF_W-1:0] a2,
  output logic              busy,
  output logic              coef_updated,
  output logic              err
);

`ifdef IIR_COEF_CHECKSUM_EN
  localparam int unsigned NumWords = NUM_COEF + 1;
`else
  localparam int unsigned NumWords = NUM_COEF;
`endif

  loader_state_e     state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [COEF_W-1:0] shadow_q [NUM_COEF];
  logic [COEF_W-1:0] shadow_d [NUM_COEF];
  logic [COEF_W-1:0] live_q   [NUM_COEF];
  logic [COEF_W-1:0] live_d   [NUM_COEF];
  logic              err_q, err_d;
  logic              upd_q, upd_d;

  logic accept;
  logic last_idx;
  logic csum_ok;

  assign s_ready  = (state_q != PENDING);
  assign accept   = s_valid & s_ready;
  assign last_idx = (idx_q == 3'(NumWords - 1));

`ifdef IIR_COEF_CHECKSUM_EN
  logic [COEF_W-1:0] csum;
  always_comb begin
    csum = '0;
    for (int unsigned i = 0; i < NUM_COEF; i++) begin
      csum = csum + shadow_q[i];
    end
    csum_ok = (s_data == csum);
  end
`else
  assign csum_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    live_d   = live_q;
    err_d    = err_q;
    upd_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shadow_d[B0_IDX] = s_data;
          idx_d            = 3'd1;
          // A one-word set is a framing error; a good first word clears the old error.
          err_d            = s_last;
          state_d          = s_last ? IDLE : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          for (int unsigned i = 0; i < NUM_COEF; i++) begin
            if (idx_q == 3'(i)) shadow_d[i] = s_data;
          end
          idx_d = idx_q + 3'd1;
          if (last_idx) begin
            if (!s_last) begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end else if (!csum_ok) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = PENDING;
            end
          end else if (s_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (accept && s_last) state_d = IDLE;
      end
      PENDING: begin
        if (commit_strobe) begin
          live_d  = shadow_q;
          upd_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '{default: '0};
      live_q   <= '{default: '0};
      err_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      live_q   <= live_d;
      err_q    <= err_d;
      upd_q    <= upd_d;
    end
  end

  assign b0           = live_q[B0_IDX];
  assign b1           = live_q[B1_IDX];
  assign b2           = live_q[B2_IDX];
  assign a1           = live_q[A1_IDX];
  assign a2           = live_q[A2_IDX];
  assign busy         = (state_q != IDLE);
  assign coef_updated = upd_q;
  assign err          = err_q;

endmodule

// File: tb/tb_iir_coef_loader.sv
// Directed self-checking bench for iir_coef_loader; checksum vectors run when
// IIR_COEF_CHECKSUM_EN is defined.
module tb_iir_coef_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        commit_strobe = 1'b0;
  logic [31:0] b0, b1, b2, a1, a2;
  logic        busy, coef_updated, err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iir_coef_loader #(.COEF_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .commit_strobe(commit_strobe),
    .b0           (b0),
    .b1           (b1),
    .b2           (b2),
    .a1           (a1),
    .a2           (a2),
    .busy         (busy),
    .coef_updated (coef_updated),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, $signed(obs), obs,
               $signed(exp), exp);
    end
  endtask

  task automatic check_live(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3,
                            input logic [31:0] e4);
    check({tag, ".b0"}, b0, e0);
    check({tag, ".b1"}, b1, e1);
    check({tag, ".b2"}, b2, e2);
    check({tag, ".a1"}, a1, e3);
    check({tag, ".a2"}, a2, e4);
  endtask

  // Drive one word from the falling edge; it is accepted on the next rising edge with s_ready.
  task automatic send_word(input logic [31:0] data, input logic last, input logic strobe);
    int waited;
    @(negedge clk);
    waited = 0;
    while (!s_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) check("ready_timeout", 32'(s_ready), 32'd1);
    s_valid       = 1'b1;
    s_data        = data;
    s_last        = last;
    commit_strobe = strobe;
    @(posedge clk);
    #1;
    s_valid       = 1'b0;
    s_last        = 1'b0;
    commit_strobe = 1'b0;
  endtask

  task automatic send_set(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input logic [31:0] w3, input logic [31:0] w4);
    send_word(w0, 1'b0, 1'b0);
    send_word(w1, 1'b0, 1'b0);
    send_word(w2, 1'b0, 1'b0);
    send_word(w3, 1'b0, 1'b0);
`ifdef IIR_COEF_CHECKSUM_EN
    send_word(w4, 1'b0, 1'b0);
    send_word(w0 + w1 + w2 + w3 + w4, 1'b1, 1'b0);
`else
    send_word(w4, 1'b1, 1'b0);
`endif
  endtask

  task automatic strobe();
    @(negedge clk);
    commit_strobe = 1'b1;
    @(posedge clk);
    #1;
    commit_strobe = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst.s_ready", 32'(s_ready), 32'd1);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.upd", 32'(coef_updated), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check_live("rst", 0, 0, 0, 0, 0);

    // Basic set, strobe a few cycles later
    send_word(32'd100, 1'b0, 1'b0);
    check("t1.busy_after_first", 32'(busy), 32'd1);
    send_word(-32'sd200, 1'b0, 1'b0);
    send_word(32'd300, 1'b0, 1'b0);
    send_word(-32'sd400, 1'b0, 1'b0);
`ifdef IIR_COEF_CHECKSUM_EN
    send_word(32'd500, 1'b0, 1'b0);
    send_word(32'd300, 1'b1, 1'b0);
`else
    send_word(32'd500, 1'b1, 1'b0);
`endif
    check("t1.pending_ready", 32'(s_ready), 32'd0);
    idle_cycles(2);
    check_live("t1.pre", 0, 0, 0, 0, 0);
    strobe();
    check_live("t1.post", 100, -32'sd200, 300, -32'sd400, 500);
    check("t1.upd_hi", 32'(coef_updated), 32'd1);
    check("t1.busy_lo", 32'(busy), 32'd0);
    idle_cycles(1);
    check("t1.upd_one_cycle", 32'(coef_updated), 32'd0);

    // Strobe coincident with the final word is ignored; wait 20 cycles, then commit
    send_word(32'd7, 1'b0, 1'b0);
    send_word(32'd8, 1'b0, 1'b0);
    send_word(32'd9, 1'b0, 1'b0);
    send_word(32'd10, 1'b0, 1'b0);
`ifdef IIR_COEF_CHECKSUM_EN
    send_word(32'd11, 1'b0, 1'b0);
    send_word(32'd45, 1'b1, 1'b1);
`else
    send_word(32'd11, 1'b1, 1'b1);
`endif
    check("t2.upd_same_cycle", 32'(coef_updated), 32'd0);
    idle_cycles(20);
    check_live("t2.hold", 100, -32'sd200, 300, -32'sd400, 500);
    check("t2.s_ready", 32'(s_ready), 32'd0);
    check("t2.busy", 32'(busy), 32'd1);
    strobe();
    check_live("t2.post", 7, 8, 9, 10, 11);
    check("t2.upd", 32'(coef_updated), 32'd1);

    // Early s_last on word 3 drops the set
    send_word(32'd1, 1'b0, 1'b0);
    send_word(32'd2, 1'b0, 1'b0);
    send_word(32'd3, 1'b1, 1'b0);
    check("t3.err", 32'(err), 32'd1);
    check("t3.busy", 32'(busy), 32'd0);
    check("t3.s_ready", 32'(s_ready), 32'd1);
    strobe();
    check("t3.no_upd", 32'(coef_updated), 32'd0);
    check_live("t3.keep", 7, 8, 9, 10, 11);
    check("t3.err_sticky", 32'(err), 32'd1);
    send_word(32'd21, 1'b0, 1'b0);
    check("t3.err_cleared", 32'(err), 32'd0);
    send_word(32'd22, 1'b0, 1'b0);
    send_word(32'd23, 1'b0, 1'b0);
    send_word(32'd24, 1'b0, 1'b0);
`ifdef IIR_COEF_CHECKSUM_EN
    send_word(32'd25, 1'b0, 1'b0);
    send_word(32'd115, 1'b1, 1'b0);
`else
    send_word(32'd25, 1'b1, 1'b0);
`endif
    strobe();
    check_live("t3.commit", 21, 22, 23, 24, 25);
    check("t3.err_after_commit", 32'(err), 32'd0);

    // Missing s_last on the final word: drain until s_last
    for (int i = 0; i < 5; i++) send_word(32'(50 + i), 1'b0, 1'b0);
`ifdef IIR_COEF_CHECKSUM_EN
    send_word(32'd260, 1'b0, 1'b0);
`endif
    check("t4.err", 32'(err), 32'd1);
    check("t4.drain_busy", 32'(busy), 32'd1);
    send_word(32'd60, 1'b0, 1'b0);
    check("t4.still_drain", 32'(busy), 32'd1);
    send_word(32'd61, 1'b1, 1'b0);
    check("t4.idle", 32'(busy), 32'd0);
    check("t4.err_hold", 32'(err), 32'd1);
    strobe();
    check("t4.no_upd", 32'(coef_updated), 32'd0);
    check_live("t4.keep", 21, 22, 23, 24, 25);

    // s_last on the very first word
    send_word(32'd5, 1'b0, 1'b0);
    check("t4b.err_cleared", 32'(err), 32'd0);
    send_word(32'd6, 1'b1, 1'b0);
    check("t4b.err_word2", 32'(err), 32'd1);
    send_word(32'd99, 1'b1, 1'b0);
    check("t4b.err_first", 32'(err), 32'd1);
    check("t4b.busy", 32'(busy), 32'd0);

    // Reset mid-load
    send_word(32'd71, 1'b0, 1'b0);
    send_word(32'd72, 1'b0, 1'b0);
    send_word(32'd73, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_live("t5.rst", 0, 0, 0, 0, 0);
    check("t5.err", 32'(err), 32'd0);
    check("t5.busy", 32'(busy), 32'd0);
    check("t5.s_ready", 32'(s_ready), 32'd1);
    send_set(32'd31, 32'd32, 32'd33, 32'd34, 32'd35);
    strobe();
    check_live("t5.commit", 31, 32, 33, 34, 35);
    check("t5.upd", 32'(coef_updated), 32'd1);

`ifdef IIR_COEF_CHECKSUM_EN
    // Checksum good then bad
    for (int i = 1; i <= 5; i++) send_word(32'(i), 1'b0, 1'b0);
    send_word(32'd15, 1'b1, 1'b0);
    check("t6.pending", 32'(s_ready), 32'd0);
    strobe();
    check_live("t6.commit", 1, 2, 3, 4, 5);
    for (int i = 1; i <= 5; i++) send_word(32'(i + 10), 1'b0, 1'b0);
    send_word(32'd66, 1'b1, 1'b0);
    check("t6.bad_err", 32'(err), 32'd1);
    check("t6.bad_idle", 32'(busy), 32'd0);
    strobe();
    check("t6.bad_no_upd", 32'(coef_updated), 32'd0);
    check_live("t6.keep", 1, 2, 3, 4, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
